impl_ram_port_arbiter: RTL
==========================

# impl_ram_port_arbiter

Two-requester arbiter for data port B of the implementation dual-port RAM. It shares the port between the core LSU (OBI-style req/gnt/rvalid) and a program loader/debug master. The core has priority, a starvation counter guarantees the loader a grant, and a registered response path routes the one-cycle-latency RAM read data back to the requester that owns it.

## Interface
Parameters:
- ADDR_WIDTH, 22, byte address width, identical to the RAM's ADDR_WIDTH
- MAX_WAIT, 4, consecutive denied loader cycles before the loader is forced to win (1..15)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- core_req_i  in  1  core request
- core_gnt_o  out  1  core grant (combinational)
- core_addr_i  in  ADDR_WIDTH  core byte address
- core_we_i  in  1  core write enable
- core_be_i  in  4  core byte enables
- core_wdata_i  in  32  core write data
- core_rvalid_o  out  1  core response valid
- core_rdata_o  out  32  core read data
- ldr_req_i, ldr_gnt_o, ldr_addr_i, ldr_we_i, ldr_be_i, ldr_wdata_i, ldr_rvalid_o, ldr_rdata_o: loader copies of the above, same directions and widths
- ldr_excl_i  in  1  loader exclusive mode; core gets no grants while high
- ram_en_o  out  1  RAM port B enable
- ram_addr_o  out  ADDR_WIDTH  RAM port B address
- ram_wdata_o  out  32  RAM port B write data
- ram_we_o  out  1  RAM port B write enable
- ram_be_o  out  4  RAM port B byte enables
- ram_rdata_i  in  32  RAM port B read data, valid one cycle after an enabled read

## Operation
- Handshake: a transfer happens in the cycle where req and gnt are both high. The requester holds req/addr/we/be/wdata stable until granted. gnt is never high without req.
- Arbitration each cycle, evaluated in this order:
  1. ldr_excl_i high: loader granted if ldr_req_i; core never granted.
  2. ldr_req_i and starve_cnt == MAX_WAIT: loader granted.
  3. core_req_i: core granted.
  4. ldr_req_i: loader granted.
- At most one grant per cycle. Back-to-back grants every cycle are supported, with any mix of owners.
- RAM drive: ram_en_o = core_gnt_o | ldr_gnt_o. ram_addr/wdata/we/be carry the winner's fields. When no grant is given, ram_we_o = 0, ram_be_o = 0, and ram_addr_o/ram_wdata_o = 0.
- starve_cnt (4 bits):
  - cleared when the loader is granted or ldr_req_i is low;
  - otherwise incremented when ldr_req_i is high and not granted, saturating at MAX_WAIT.
- Response register, loaded every cycle:
  - resp_valid <= any grant;
  - resp_owner <= ldr_gnt_o;
  - resp_is_read <= winner's ~we.
- Responses:
  - core_rvalid_o = resp_valid & ~resp_owner; ldr_rvalid_o = resp_valid & resp_owner.
  - The selected rdata = ram_rdata_i when resp_is_read, else 32'h0. The non-owner's rdata is always 32'h0.
- Writes produce exactly one rvalid pulse, with zero data.
- Address alignment is not altered here. The RAM word-aligns internally.

## Timing
- Grant latency: 0 cycles (combinational from req and state).
- Response latency: exactly 1 cycle after the grant cycle. There is no response backpressure and no outstanding limit beyond one per cycle.
- Reset values: core_gnt_o = ldr_gnt_o = 0 while rst_i is high, regardless of req. All rvalid outputs 0, all rdata outputs 0, ram_en_o = 0, starve_cnt = 0, resp_valid = 0.
- Reset asserted in the cycle after a grant: that grant's rvalid is suppressed (resp_valid cleared). The RAM access already issued is not undone.
- ldr_excl_i rising while core_req_i is pending: the core stalls from that cycle on. The core's in-flight response from the previous cycle is still delivered.
- starve_cnt counts only while the loader is requesting. It does not count in exclusive mode, because the loader is always granted there.
- Simultaneous requests every cycle with MAX_WAIT = 4: grant pattern is core ×4, loader ×1, repeating.

## Test plan
- Reset: hold rst_i for 3 cycles with both reqs high -> no gnt, no rvalid, ram_en_o = 0. First grant goes to the core in the cycle after rst_i falls.
- Core read: preload word 0x100 = 32'hDEADBEEF, core_req with addr 0x100, we = 0 -> core_gnt in cycle N, core_rvalid with core_rdata = 32'hDEADBEEF in N+1, ldr_rvalid = 0.
- Loader write then core read: loader writes 32'h12345678 with be = 4'b0011 to 0x200 (prior value 0) -> ldr_rvalid with rdata 0 in N+1. A following core read of 0x200 returns 32'h00005678.
- Starvation: both reqs held high for 10 cycles, MAX_WAIT = 4 -> grants core, core, core, core, ldr, core, core, core, core, ldr, with one rvalid per cycle routed to the matching owner.
- Exclusive mode: ldr_excl_i high with both reqs high for 5 cycles -> 5 loader grants, core_gnt = 0 throughout. Core granted in the first cycle after ldr_excl_i drops.
- Reset mid-flight: core read granted in cycle N, rst_i high in N+1 -> core_rvalid = 0 in N+1, and no response appears later.

Source files
------------

// File: rtl/impl_ram_port_arbiter.sv
// Port-B arbiter for the implementation RAM: core LSU has priority, the loader
// is guaranteed service by a starvation counter, read data is routed back one cycle later.
module impl_ram_port_arbiter #(
    parameter int ADDR_WIDTH = 22,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  core_req_i,
    output logic                  core_gnt_o,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    input  logic                  core_we_i,
    input  logic [3:0]            core_be_i,
    input  logic [31:0]           core_wdata_i,
    output logic                  core_rvalid_o,
    output logic [31:0]           core_rdata_o,

    input  logic                  ldr_req_i,
    output logic                  ldr_gnt_o,
    input  logic [ADDR_WIDTH-1:0] ldr_addr_i,
    input  logic                  ldr_we_i,
    input  logic [3:0]            ldr_be_i,
    input  logic [31:0]           ldr_wdata_i,
    output logic                  ldr_rvalid_o,
    output logic [31:0]           ldr_rdata_o,
    input  logic                  ldr_excl_i,

    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    input  logic [31:0]           ram_rdata_i
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] starve_cnt;
    logic       core_win_p0;
    logic       ldr_win_p0;
    logic       winner_we_p0;

    logic       vld_p1;
    logic       owner_p1;
    logic       is_read_p1;

    function automatic logic [31:0] resp_data(input logic sel, input logic is_read,
                                              input logic [31:0] rdata);
        return (sel && is_read) ? rdata : 32'h0;
    endfunction

    // Stage p0: combinational arbitration and RAM drive
    always_comb begin
        core_win_p0 = 1'b0;
        ldr_win_p0  = 1'b0;
        if (!rst_i) begin
            if (ldr_excl_i) begin
                ldr_win_p0 = ldr_req_i;
            end else if (ldr_req_i && (starve_cnt == WAIT_LIMIT)) begin
                ldr_win_p0 = 1'b1;
            end else if (core_req_i) begin
                core_win_p0 = 1'b1;
            end else if (ldr_req_i) begin
                ldr_win_p0 = 1'b1;
            end
        end
    end

    assign core_gnt_o = core_win_p0;
    assign ldr_gnt_o  = ldr_win_p0;
    assign ram_en_o   = core_win_p0 | ldr_win_p0;

    always_comb begin
        ram_addr_o  = '0;
        ram_wdata_o = 32'h0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        if (core_win_p0) begin
            ram_addr_o  = core_addr_i;
            ram_wdata_o = core_wdata_i;
            ram_we_o    = core_we_i;
            ram_be_o    = core_be_i;
        end else if (ldr_win_p0) begin
            ram_addr_o  = ldr_addr_i;
            ram_wdata_o = ldr_wdata_i;
            ram_we_o    = ldr_we_i;
            ram_be_o    = ldr_be_i;
        end
    end

    assign winner_we_p0 = ram_we_o;

    // Counter only advances while the loader is requesting and losing
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt <= 4'h0;
        end else if (!ldr_req_i || ldr_win_p0) begin
            starve_cnt <= 4'h0;
        end else if (starve_cnt != WAIT_LIMIT) begin
            starve_cnt <= starve_cnt + 4'h1;
        end
    end

    // Stage p1: response tracking register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= core_win_p0 | ldr_win_p0;
        end
    end

    always_ff @(posedge clk_i) begin
        owner_p1   <= ldr_win_p0;
        is_read_p1 <= ~winner_we_p0;
    end

    // Gating with rst_i drops a response whose grant preceded a reset cycle
    assign core_rvalid_o = vld_p1 & ~owner_p1 & ~rst_i;
    assign ldr_rvalid_o  = vld_p1 &  owner_p1 & ~rst_i;
    assign core_rdata_o  = resp_data(core_rvalid_o, is_read_p1, ram_rdata_i);
    assign ldr_rdata_o   = resp_data(ldr_rvalid_o, is_read_p1, ram_rdata_i);

endmodule
